// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - router input unit with NUM_VC credit-managed virtual-channel FIFOs
//
// Purpose:
//   Holds NUM_VC independent first-word-fall-through FIFOs of DEPTH flits each.
//   One head flit per cycle is offered downstream, chosen round-robin among the
//   non-empty VCs. Every pop returns a one-cycle credit pulse to the upstream
//   router for the VC that was popped.
//
// Optional feature macro: VC_BUF_PRIO_EN
//   Defined   : VC0 has strict priority; round-robin covers VC1..NUM_VC-1 only,
//               and the RR pointer moves only on grants to non-zero VCs.
//   Undefined : plain round-robin over all VCs.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high reset
//   in_valid       in   upstream flit present this cycle
//   in_vc          in   target VC of the incoming flit
//   in_flit        in   incoming flit
//   out_valid      out  a flit is presented on out_flit
//   out_vc         out  VC of the presented flit
//   out_flit       out  head flit of the selected VC
//   out_ready      in   downstream accepts the presented flit
//   credit_out     out  registered one-cycle credit pulse per VC
//   vc_occupancy   out  per-VC flit count, VC i at [i*(PTR_W+1) +: PTR_W+1]
//   overflow_err   out  sticky: a flit arrived for a full VC and was dropped

module vc_input_buffer #(
    parameter int FLIT_W = 16,
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int VC_W  = $clog2(NUM_VC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [VC_W-1:0]               in_vc,
    input  logic [FLIT_W-1:0]             in_flit,
    output logic                          out_valid,
    output logic [VC_W-1:0]               out_vc,
    output logic [FLIT_W-1:0]             out_flit,
    input  logic                          out_ready,
    output logic [NUM_VC-1:0]             credit_out,
    output logic [NUM_VC*(PTR_W+1)-1:0]   vc_occupancy,
    output logic                          overflow_err
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef VC_BUF_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    // Flit storage; deliberately not reset, validity is tracked by the counts.
    logic [FLIT_W-1:0] mem_q [NUM_VC][DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_VC];
    logic [CNT_W-1:0]  count_q  [NUM_VC];
    logic [CNT_W-1:0]  count_d  [NUM_VC];
    logic [VC_W-1:0]   rr_q, rr_d;
    logic [NUM_VC-1:0] credit_q, credit_d;
    logic              overflow_q, overflow_d;

    logic [VC_W-1:0]   sel;
    logic [VC_W-1:0]   cand;
    logic              any_valid;
    logic              pop;
    logic              in_full;
    logic              same_vc_pop;
    logic              push_ok;
    logic [NUM_VC-1:0] push_vec;
    logic [NUM_VC-1:0] pop_vec;

    // Grant selection from registered state only: scan upward from rr_q+1.
    // In priority mode VC0 is excluded from the scan and overrides it instead.
    always_comb begin
        sel       = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_VC; i++) begin
            cand = VC_W'((int'(rr_q) + i) % NUM_VC);
            if (!any_valid && (count_q[cand] != '0) && !(PRIO_EN && (cand == '0))) begin
                sel       = cand;
                any_valid = 1'b1;
            end
        end
        if (PRIO_EN && (count_q[0] != '0)) begin
            sel       = '0;
            any_valid = 1'b1;
        end
    end

    always_comb begin
        pop         = any_valid && out_ready;
        in_full     = (count_q[in_vc] == FULL_CNT);
        // A full VC can still take a flit when its head leaves in the same cycle.
        same_vc_pop = pop && (sel == in_vc);
        push_ok     = in_valid && (!in_full || same_vc_pop);
        overflow_d  = overflow_q | (in_valid && in_full && !same_vc_pop);

        rr_d     = rr_q;
        credit_d = '0;
        if (pop) begin
            credit_d[sel] = 1'b1;
            if (!PRIO_EN || (sel != '0)) begin
                rr_d = sel;
            end
        end

        push_vec = '0;
        pop_vec  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push_vec[v] = push_ok && (in_vc == VC_W'(v));
            pop_vec[v]  = pop && (sel == VC_W'(v));
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            count_d[v]  = count_q[v];
            if (push_vec[v]) begin
                wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
            end
            if (pop_vec[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
            end
            if (push_vec[v] && !pop_vec[v]) begin
                count_d[v] = count_q[v] + CNT_W'(1);
            end else if (pop_vec[v] && !push_vec[v]) begin
                count_d[v] = count_q[v] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            // Parked on the last VC so the first grant lands on VC0.
            rr_q       <= VC_W'(NUM_VC - 1);
            credit_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                count_q[v]  <= count_d[v];
            end
            rr_q       <= rr_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[in_vc][wr_ptr_q[in_vc]] <= in_flit;
        end
    end

    always_comb begin
        out_valid = any_valid;
        out_vc    = sel;
        out_flit  = any_valid ? mem_q[sel][rd_ptr_q[sel]] : '0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_occupancy[v*CNT_W +: CNT_W] = count_q[v];
        end
    end

    assign credit_out   = credit_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb/tb_vc_input_buffer.sv - self-checking bench for vc_input_buffer against a queue-based model
module tb_vc_input_buffer;

    localparam int FLIT_W = 16;
    localparam int NUM_VC = 2;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int VC_W   = $clog2(NUM_VC);
    localparam int OCC_W  = NUM_VC * (PTR_W + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic [VC_W-1:0]     in_vc;
    logic [FLIT_W-1:0]   in_flit;
    logic                out_valid;
    logic [VC_W-1:0]     out_vc;
    logic [FLIT_W-1:0]   out_flit;
    logic                out_ready;
    logic [NUM_VC-1:0]   credit_out;
    logic [OCC_W-1:0]    vc_occupancy;
    logic                overflow_err;

    int checks   = 0;
    int failures = 0;

    logic [FLIT_W-1:0] mq [NUM_VC][$];
    int                m_rr;
    logic              m_ovf;
    logic [NUM_VC-1:0] m_credit;
    logic [FLIT_W-1:0] pop_log [$];
    int                vc_log  [$];

    vc_input_buffer #(.FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .in_flit      (in_flit),
        .out_valid    (out_valid),
        .out_vc       (out_vc),
        .out_flit     (out_flit),
        .out_ready    (out_ready),
        .credit_out   (credit_out),
        .vc_occupancy (vc_occupancy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Next VC to be served: first non-empty VC after the last one served.
    function automatic int model_sel();
`ifdef VC_BUF_PRIO_EN
        if (mq[0].size() != 0) return 0;
`endif
        for (int i = 1; i <= NUM_VC; i++) begin
            int c;
            c = (m_rr + i) % NUM_VC;
`ifdef VC_BUF_PRIO_EN
            if (c != 0 && mq[c].size() != 0) return c;
`else
            if (mq[c].size() != 0) return c;
`endif
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int v = 0; v < NUM_VC; v++) mq[v].delete();
        m_rr     = NUM_VC - 1;
        m_ovf    = 1'b0;
        m_credit = '0;
    endtask

    task automatic check_all();
        int s;
        logic [OCC_W-1:0]  occ;
        logic [FLIT_W-1:0] ef;
        logic [VC_W-1:0]   ev;
        s  = model_sel();
        ef = '0;
        ev = '0;
        if (s >= 0) begin
            ef = mq[s][0];
            ev = VC_W'(s);
        end
        occ = '0;
        for (int v = 0; v < NUM_VC; v++) occ[v*(PTR_W+1) +: PTR_W+1] = (PTR_W+1)'(mq[v].size());
        chk("out_valid", out_valid, 64'(s >= 0));
        chk("out_vc", out_vc, ev);
        chk("out_flit", out_flit, ef);
        chk("credit_out", credit_out, m_credit);
        chk("vc_occupancy", vc_occupancy, occ);
        chk("overflow_err", overflow_err, m_ovf);
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the next falling edge.
    task automatic step(input logic v, input int vc, input logic [FLIT_W-1:0] f, input logic rdy);
        int   s;
        logic pop;
        logic acc;
        in_valid  = v;
        in_vc     = VC_W'(vc);
        in_flit   = f;
        out_ready = rdy;
        s   = model_sel();
        pop = rdy && (s >= 0);
        acc = v && ((mq[vc].size() < DEPTH) || (pop && s == vc));
        @(posedge clk);
        m_credit = '0;
        if (pop) begin
            pop_log.push_back(mq[s].pop_front());
            vc_log.push_back(s);
            m_credit[s] = 1'b1;
`ifdef VC_BUF_PRIO_EN
            if (s != 0) m_rr = s;
`else
            m_rr = s;
`endif
        end
        if (v) begin
            if (acc) mq[vc].push_back(f);
            else     m_ovf = 1'b1;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vc     = '0;
        in_flit   = '0;
        out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        check_all();
        pop_log.delete();
        vc_log.delete();
    endtask

    initial begin
        int pulses;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_vc     = '0;
        in_flit   = '0;
        out_ready = 1'b0;
        model_clear();
        #1;
        check_all();
        do_reset();

        // Mid-operation reset clears everything without waiting for an edge.
        step(1, 0, 16'h0E01, 0);
        step(1, 1, 16'h0E02, 0);
        step(1, 0, 16'h0E03, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 model_clear();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        check_all();

        // Fill VC0 with downstream stalled, then overflow it.
        for (int i = 0; i < 4; i++) step(1, 0, 16'h1001 + 16'(i), 0);
        step(1, 0, 16'h1005, 0);
        chk("ovf_occ", vc_occupancy, 6'h04);
        chk("ovf_head", out_flit, 16'h1001);
        chk("ovf_flag", overflow_err, 1'b1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("ovf_sticky", overflow_err, 1'b1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        chk("ovf_drop_order", {pop_log[0], pop_log[3]}, {16'h1001, 16'h1004});
        chk("ovf_drop_count", pop_log.size(), 4);

        // Round-robin interleave of two VCs.
        do_reset();
        step(1, 0, 16'hA001, 0);
        step(1, 1, 16'hB001, 0);
        step(1, 0, 16'hA002, 0);
        step(1, 1, 16'hB002, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
`ifdef VC_BUF_PRIO_EN
        chk("rr_order", {pop_log[0], pop_log[1], pop_log[2], pop_log[3]},
            {16'hA001, 16'hA002, 16'hB001, 16'hB002});
`else
        chk("rr_order", {pop_log[0], pop_log[1], pop_log[2], pop_log[3]},
            {16'hA001, 16'hB001, 16'hA002, 16'hB002});
        chk("rr_vcs", {vc_log[0], vc_log[1], vc_log[2], vc_log[3]}, {32'd0, 32'd1, 32'd0, 32'd1});
`endif

        // Push into a full VC while its head is popping.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 16'h2001 + 16'(i), 0);
        step(1, 0, 16'h2000, 1);
        chk("fullpush_occ", vc_occupancy, 6'h04);
        chk("fullpush_ovf", overflow_err, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        chk("fullpush_order", {pop_log[0], pop_log[1], pop_log[2], pop_log[3], pop_log[4]},
            {16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h2000});

        // Streaming through VC1 wraps the pointers several times.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 16'h3000 + 16'(i), 1);
            chk("stream_latency", out_flit, 16'h3000 + 16'(i));
            if (credit_out[1]) pulses++;
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            if (credit_out[1]) pulses++;
        end
        chk("stream_credits", pulses, 10);
        chk("stream_last", pop_log[9], 16'h3009);

`ifdef VC_BUF_PRIO_EN
        do_reset();
        step(1, 0, 16'h00C1, 0);
        step(1, 0, 16'h00C2, 0);
        step(1, 1, 16'h00D1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        chk("prio_order", {pop_log[0], pop_log[1], pop_log[2]}, {16'h00C1, 16'h00C2, 16'h00D1});
`endif

        // Random traffic: a stall-heavy phase to provoke full VCs, then a drain-heavy phase.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic rdy;
            if (i < 300) rdy = ($urandom_range(0, 3) == 0);
            else         rdy = ($urandom_range(0, 3) != 0);
            step(logic'($urandom_range(0, 1)), int'($urandom_range(0, NUM_VC - 1)),
                 FLIT_W'($urandom), rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
